// File: rtl/pipe_chain.sv
// Elastic chain of DEPTH valid/data register stages with flush and sync active-low reset.
// Optional macro PIPE_CHAIN_BUBBLE_COLLAPSE_EN: per-stage advance so empty stages fill while the output stalls.

module pipe_chain_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (adv)
                valid <= prev_valid;
            // data is don't-care once invalid, so flush only drops the valid bit
            if (adv && !flush)
                data <= prev_data;
        end
    end
endmodule

module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
    output logic [4:0]       count_o
);
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            prev_valid;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] prev_data;
    logic [4:0]                  count;

    assign adv[DEPTH-1] = !valid[DEPTH-1] | out_ready_i;

    generate
        for (genvar k = 0; k < DEPTH-1; k++) begin : g_adv
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
            assign adv[k] = !valid[k] | adv[k+1];
`else
            assign adv[k] = adv[DEPTH-1];
`endif
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign prev_valid[k] = in_valid_i;
                assign prev_data[k]  = in_data_i;
            end else begin : g_rest
                assign prev_valid[k] = valid[k-1];
                assign prev_data[k]  = data[k-1];
            end

            pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
                .clk        (clk_i),
                .rst_n      (rst_i),
                .flush      (flush_i),
                .adv        (adv[k]),
                .prev_valid (prev_valid[k]),
                .prev_data  (prev_data[k]),
                .valid      (valid[k]),
                .data       (data[k])
            );
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++)
            count = count + 5'(valid[k]);
    end

    // handshakes are masked during reset/flush so nothing transfers on a discarding edge
    assign in_ready_o  = adv[0] & rst_i & !flush_i;
    assign out_valid_o = valid[DEPTH-1] & rst_i & !flush_i;
    assign out_data_o  = data[DEPTH-1];
    assign count_o     = count;
endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: directed scenarios plus random traffic, checked against an in-flight queue.

module tb_pipe_chain;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] out_data_o;
    logic             flush_i = 1'b0;
    logic [4:0]       count_o;

    int n_chk = 0, n_fail = 0, n_in = 0, n_out = 0;
    bit mon_en = 0, post_rst = 0, prev_stall = 0;
    logic [WIDTH-1:0] prev_data = '0;
    logic [WIDTH-1:0] sb[$];

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .flush_i     (flush_i),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive one cycle's inputs, then return just after the following falling edge
    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input logic rs);
        @(posedge clk_i);
        #1;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        rst_i       = rs;
        @(negedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Model: the chain is a FIFO of in-flight items; count equals its occupancy.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("count_vs_model", 64'(count_o), 64'(sb.size()));
            if (post_rst) begin
                chk("data_after_reset", 64'(out_data_o), 64'(0));
                post_rst = 0;
            end
            if (!rst_i) begin
                chk("rst_in_ready", 64'(in_ready_o), 64'(0));
                chk("rst_out_valid", 64'(out_valid_o), 64'(0));
                sb.delete();
                post_rst   = 1;
                prev_stall = 0;
            end else if (flush_i) begin
                chk("flush_in_ready", 64'(in_ready_o), 64'(0));
                chk("flush_out_valid", 64'(out_valid_o), 64'(0));
                sb.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid_o), 64'(1));
                    chk("stall_data", 64'(out_data_o), 64'(prev_data));
                end
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
                chk("collapse_in_ready", 64'(in_ready_o),
                    64'((sb.size() < DEPTH) || out_ready_i));
`endif
                if (out_valid_o && out_ready_i) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL out_underflow: got item %0h expected none", out_data_o);
                    end else begin
                        chk("out_data", 64'(out_data_o), 64'(sb.pop_front()));
                    end
                end
                if (in_valid_i && in_ready_o) begin
                    n_in++;
                    sb.push_back(in_data_i);
                end
                prev_stall = out_valid_o && !out_ready_i;
                prev_data  = out_data_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] items[6];
        logic [WIDTH-1:0] a, b;
        int idx, n_in0, n_out0;
        logic exp_v[5];
        logic [WIDTH-1:0] exp_d[5];

        // reset state
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1;
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 64'(count_o), 64'(0));
        chk("reset_out_valid", 64'(out_valid_o), 64'(0));
        chk("reset_out_data", 64'(out_data_o), 64'(0));
        chk("reset_in_ready", 64'(in_ready_o), 64'(0));
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // latency: three back-to-back pushes, output after DEPTH-1 further edges
        tick(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 32'h33, 1'b1, 1'b0, 1'b1);
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
            if (i == 0) chk("lat_count_peak", 64'(count_o), 64'(3));
            chk("lat_out_valid", 64'(out_valid_o), 64'(exp_v[i]));
            if (exp_v[i]) chk("lat_out_data", 64'(out_data_o), 64'(exp_d[i]));
        end

        // backpressure: only DEPTH accepts while the output is blocked
        reset_dut();
        foreach (items[i]) items[i] = $urandom;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, items[idx < 6 ? idx : 5], 1'b0, 1'b0, 1'b1);
            if (in_ready_o) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'(DEPTH));
        chk("bp_count", 64'(count_o), 64'(DEPTH));
        chk("bp_in_ready", 64'(in_ready_o), 64'(0));
        n_out0 = n_out;
        for (int i = 0; i < 20 && !(idx == 6 && count_o == 0); i++) begin
            tick(idx < 6, items[idx < 6 ? idx : 5], 1'b1, 1'b0, 1'b1);
            if (idx < 6 && in_ready_o) idx++;
        end
        chk("bp_out_total", 64'(n_out - n_out0), 64'(6));
        chk("bp_drained", 64'(count_o), 64'(0));

        // bubble between A and B while A is blocked at the output
        reset_dut();
        a = $urandom;
        b = $urandom;
        tick(1'b1, a, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, b, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
            chk("bub_count", 64'(count_o), 64'(2));
            chk("bub_head_valid", 64'(out_valid_o), 64'(1));
            chk("bub_head_data", 64'(out_data_o), 64'(a));
`ifndef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
            chk("bub_in_ready", 64'(in_ready_o), 64'(0));
`endif
        end
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
        chk("bub_collapsed", 64'(out_valid_o), 64'(1));
        chk("bub_b_data", 64'(out_data_o), 64'(b));
`else
        chk("bub_kept", 64'(out_valid_o), 64'(0));
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("bub_b_valid", 64'(out_valid_o), 64'(1));
        chk("bub_b_data", 64'(out_data_o), 64'(b));
`endif
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // full chain streaming: one in and one out per cycle
        reset_dut();
        for (int i = 0; i < 10 && count_o != DEPTH; i++)
            tick(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        chk("full_count", 64'(count_o), 64'(DEPTH));
        n_in0  = n_in;
        n_out0 = n_out;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
            chk("stream_count", 64'(count_o), 64'(DEPTH));
        end
        chk("stream_in", 64'(n_in - n_in0), 64'(10));
        chk("stream_out", 64'(n_out - n_out0), 64'(10));

        // flush with three items in flight
        reset_dut();
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("pre_flush_count", 64'(count_o), 64'(3));
        n_in0  = n_in;
        n_out0 = n_out;
        tick(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("flush_no_in", 64'(n_in - n_in0), 64'(0));
        chk("flush_no_out", 64'(n_out - n_out0), 64'(0));
        chk("post_flush_count", 64'(count_o), 64'(0));
        a = $urandom;
        tick(1'b1, a, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8 && !out_valid_o; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("post_flush_valid", 64'(out_valid_o), 64'(1));
        chk("post_flush_data", 64'(out_data_o), 64'(a));
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // reset mid-stream with two items, output ready
        reset_dut();
        tick(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        tick(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_count", 64'(count_o), 64'(2));
        n_out0 = n_out;
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("midrst_no_out", 64'(n_out - n_out0), 64'(0));
        chk("midrst_out_valid", 64'(out_valid_o), 64'(0));
        chk("midrst_out_data", 64'(out_data_o), 64'(0));
        chk("midrst_count", 64'(count_o), 64'(0));

        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            tick($urandom_range(9) < 7, $urandom, $urandom_range(9) < 6,
                 $urandom_range(49) == 0, $urandom_range(99) != 0);
        for (int i = 0; i < 3 * DEPTH; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("final_count", 64'(count_o), 64'(0));
        chk("final_model_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal 1..256).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal 1..16).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid_i  input  1  upstream item present.
REQ-006 SHALL have port in_ready_o  output  1  chain accepts item this cycle.
REQ-007 SHALL have port in_data_i  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid_o  output  1  item present at the last stage.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts the item.
REQ-010 SHALL have port out_data_o  output  WIDTH  payload of the last stage.
REQ-011 SHALL have port flush_i  input  1  discard all items in flight.
REQ-012 SHALL have port count_o  output  5  number of valid stages, 0..DEPTH.

Function
REQ-013 SHALL hold DEPTH stages, stage 0 nearest input, stage DEPTH-1 driving out_*; each stage has a WIDTH data register and a valid bit.
REQ-014 SHALL drive out_valid_o = valid[DEPTH-1], out_data_o = data[DEPTH-1], count_o = popcount(valid), all directly from registers.
REQ-015 SHALL count an input transfer when in_valid_i & in_ready_o, and an output transfer when out_valid_o & out_ready_i, both sampled at the rising edge.
REQ-016 SHALL compute per-stage advance: adv[DEPTH-1] = !valid[DEPTH-1] | out_ready_i; in_ready_o = adv[0].
REQ-017 On adv[k], stage k SHALL load valid and data from stage k-1 (stage 0 loads in_valid_i and in_data_i); otherwise stage k SHALL hold.
REQ-018 SHALL present an item accepted at edge n on out_* after edge n+DEPTH-1 when never stalled (DEPTH=1: visible right after the accepting edge).
REQ-019 SHALL sustain one transfer per cycle in and out while out_ready_i stays high.
REQ-020 When full with out_ready_i high, an input and an output transfer SHALL both complete in the same cycle, with count_o unchanged.
REQ-021 SHALL never drop, duplicate or reorder items; out_data_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-022 While flush_i=1, in_ready_o and out_valid_o SHALL be forced 0, so no transfer occurs; at the edge all valid bits SHALL clear and data registers SHALL hold.
REQ-023 When out_valid_o=0, out_data_o SHALL carry no meaning; data in invalid stages SHALL carry no meaning.

Reset
REQ-024 When rst_i=0 at a rising edge, all valid bits SHALL clear and all data registers SHALL become 0; count_o=0, out_valid_o=0, out_data_o=0 afterwards.
REQ-025 While rst_i=0, in_ready_o SHALL be forced 0.
REQ-026 Reset SHALL take priority over flush_i; reset mid-stream SHALL discard all in-flight items with no output transfer in that cycle.

Configuration
REQ-027 SHALL have macro PIPE_CHAIN_BUBBLE_COLLAPSE_EN.
REQ-028 With PIPE_CHAIN_BUBBLE_COLLAPSE_EN defined, for k<DEPTH-1: adv[k] = !valid[k] | adv[k+1], so empty stages fill while the output stalls.
REQ-029 Without PIPE_CHAIN_BUBBLE_COLLAPSE_EN, adv[k] = adv[DEPTH-1] for all k: global stall, bubbles are preserved and in_ready_o = !valid[DEPTH-1] | out_ready_i.

Verification
REQ-030 DEPTH=4, WIDTH=32, out_ready_i=1, push 0x11,0x22,0x33 back-to-back -> out_valid_o rises 3 cycles after the first accept; 0x11,0x22,0x33 appear on consecutive cycles; count_o peaks at 3.
REQ-031 Collapse enabled, out_ready_i=0, push 6 items -> in_ready_o falls after 4 accepts with count_o=4; raise out_ready_i -> 6 items out in order, then count_o=0.
REQ-032 Collapse disabled, push A, one idle cycle, push B, then hold out_ready_i=0 with A at the output -> count_o stays 2, the bubble between A and B is kept, and in_ready_o=0.
REQ-033 Full chain, in_valid_i=1, out_ready_i=1 for 10 cycles -> 10 in and 10 out transfers, count_o constant at 4, data order preserved.
REQ-034 Chain holding 3 items, flush_i=1 for one cycle with in_valid_i=1 -> no transfers that cycle, count_o=0 next cycle, the flushed items never appear, and the next accepted item emerges normally.
REQ-035 Chain holding 2 items, rst_i=0 for one edge with out_ready_i=1 -> no output transfer; next cycle out_valid_o=0, out_data_o=0, count_o=0; in_ready_o=0 during reset.
